traffic_ctrl_param: RTL and testbench

Parametrised two-road (NS/EW) signal controller and successor to the fixed 10/3/10/3 tick controller. Phase durations, extension step and extension cap are parameters. The block adds all-red clearance phases, per-direction green extension with a per-phase cap, and a flashing-yellow fault/maintenance mode. It sits behind the tick prescaler: `tick` is a one-clk enable pulse, and all timing is counted in ticks.

---
 rtl/traffic_ctrl_param.sv | 171 +++++++++++++++++
 tb/tb_traffic_ctrl_param.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_param.sv
// Parametrised NS/EW signal controller with all-red clearance, capped green extension
// and a flashing-yellow maintenance mode. All timing is counted in prescaled ticks.
module traffic_ctrl_param #(
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned GREEN_NS = 10,
  parameter int unsigned GREEN_EW = 10,
  parameter int unsigned YELLOW   = 3,
  parameter int unsigned ALL_RED  = 1,
  parameter int unsigned EXT_STEP = 5,
  parameter int unsigned EXT_MAX  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             ext_ns,
  input  logic             ext_ew,
  input  logic             flash,
  output logic             ns_green,
  output logic             ns_yellow,
  output logic             ns_red,
  output logic             ew_green,
  output logic             ew_yellow,
  output logic             ew_red,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] timer,
  output logic             cycle_start
);

  typedef enum logic [2:0] {
    StNsGreen  = 3'd0,
    StNsYellow = 3'd1,
    StAr1      = 3'd2,
    StEwGreen  = 3'd3,
    StEwYellow = 3'd4,
    StAr2      = 3'd5,
    StFlash    = 3'd6
  } phase_e;

  localparam int unsigned GreenMax = (GREEN_NS > GREEN_EW) ? GREEN_NS : GREEN_EW;
  localparam int unsigned TimerMax = GreenMax + EXT_MAX * EXT_STEP;
  localparam longint unsigned CntSpan = 64'd1 << CNT_W;
  localparam bit CntWOk = 64'(TimerMax) < CntSpan;

  localparam int unsigned ExtW = (EXT_MAX == 0) ? 1 : $clog2(EXT_MAX + 1);

  localparam logic [CNT_W-1:0] TOne    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TStep   = CNT_W'(EXT_STEP);
  localparam logic [CNT_W-1:0] TNsG    = CNT_W'(GREEN_NS);
  localparam logic [CNT_W-1:0] TEwG    = CNT_W'(GREEN_EW);
  localparam logic [CNT_W-1:0] TYellow = CNT_W'(YELLOW);
  localparam logic [CNT_W-1:0] TAllRed = CNT_W'(ALL_RED);
  localparam logic [ExtW-1:0]  ExtCap  = ExtW'(EXT_MAX);

  // Lamp vector order: {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red}
  localparam logic [5:0] LampAllRed = 6'b001_001;
  localparam logic [5:0] LampNsG    = 6'b100_001;
  localparam logic [5:0] LampNsY    = 6'b010_001;
  localparam logic [5:0] LampEwG    = 6'b001_100;
  localparam logic [5:0] LampEwY    = 6'b001_010;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [ExtW-1:0]  ext_cnt_q, ext_cnt_d;
  logic             flash_yel_q, flash_yel_d;
  logic [5:0]       lamp_q, lamp_d;
  logic             cycle_start_q, cycle_start_d;
  logic             ext_req;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      StAr2:      next_phase = StNsGreen;
      StNsGreen:  next_phase = StNsYellow;
      StNsYellow: next_phase = StAr1;
      StAr1:      next_phase = StEwGreen;
      StEwGreen:  next_phase = StEwYellow;
      default:    next_phase = StAr2;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] phase_dur(input phase_e p);
    case (p)
      StNsGreen:             phase_dur = TNsG;
      StEwGreen:             phase_dur = TEwG;
      StNsYellow, StEwYellow: phase_dur = TYellow;
      StAr1, StAr2:          phase_dur = TAllRed;
      default:               phase_dur = '0;
    endcase
  endfunction

  always_comb begin
    phase_d     = phase_q;
    timer_d     = timer_q;
    ext_cnt_d   = ext_cnt_q;
    flash_yel_d = flash_yel_q;
    ext_req     = ((phase_q == StNsGreen) && ext_ns) || ((phase_q == StEwGreen) && ext_ew);

    if (flash) begin
      // Flash overrides tick; yellows start lit on entry and toggle per tick afterwards.
      phase_d     = StFlash;
      timer_d     = '0;
      ext_cnt_d   = '0;
      flash_yel_d = (phase_q == StFlash) ? (flash_yel_q ^ tick) : 1'b1;
    end else begin
      case (phase_q)
        StNsGreen, StNsYellow, StAr1, StEwGreen, StEwYellow, StAr2: begin
          if (tick) begin
            if (ext_req && (ext_cnt_q < ExtCap)) begin
              timer_d   = timer_q - TOne + TStep;
              ext_cnt_d = ext_cnt_q + ExtW'(1);
            end else if (timer_q > TOne) begin
              timer_d = timer_q - TOne;
            end else begin
              phase_d   = next_phase(phase_q);
              timer_d   = phase_dur(phase_d);
              ext_cnt_d = '0;
            end
          end
        end
        default: begin
          // Leaving flash, or recovering from the unused code, restarts through clearance.
          phase_d     = StAr2;
          timer_d     = TAllRed;
          ext_cnt_d   = '0;
          flash_yel_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    lamp_d = LampAllRed;
    case (phase_d)
      StNsGreen:  lamp_d = LampNsG;
      StNsYellow: lamp_d = LampNsY;
      StEwGreen:  lamp_d = LampEwG;
      StEwYellow: lamp_d = LampEwY;
      StFlash:    lamp_d = {1'b0, flash_yel_d, 1'b0, 1'b0, flash_yel_d, 1'b0};
      default:    lamp_d = LampAllRed;
    endcase
    cycle_start_d = (phase_d == StNsGreen) && (phase_q != StNsGreen);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= StAr2;
      timer_q       <= TAllRed;
      ext_cnt_q     <= '0;
      flash_yel_q   <= 1'b0;
      lamp_q        <= LampAllRed;
      cycle_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      timer_q       <= timer_d;
      ext_cnt_q     <= ext_cnt_d;
      flash_yel_q   <= flash_yel_d;
      lamp_q        <= lamp_d;
      cycle_start_q <= cycle_start_d;
    end
  end

  // The timer must hold the longest fully extended green without wrapping.
  always_ff @(posedge clk) begin
    assert (CntWOk) else $error("CNT_W too narrow for longest extended green");
  end

  assign {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red} = lamp_q;
  assign phase       = phase_q;
  assign timer       = timer_q;
  assign cycle_start = cycle_start_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: directed scenarios plus randomized traffic checked
// against a tick-level behavioural model of the signal plan.
module tb_traffic_ctrl_param;

  localparam int CNT_W    = 6;
  localparam int GREEN_NS = 10;
  localparam int GREEN_EW = 10;
  localparam int YELLOW   = 3;
  localparam int ALL_RED  = 1;
  localparam int EXT_STEP = 5;
  localparam int EXT_MAX  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic ext_ns = 1'b0;
  logic ext_ew = 1'b0;
  logic flash = 1'b0;
  logic ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red;
  logic [2:0] phase;
  logic [CNT_W-1:0] timer;
  logic cycle_start;
  logic [5:0] lamps;

  int passed = 0;
  int total = 0;

  // Model of the plan: phase index, ticks left, extensions used, flash yellow level.
  int m_phase, m_timer, m_ext;
  bit m_fy, m_cs;
  int dur_tab[6] = '{GREEN_NS, YELLOW, ALL_RED, GREEN_EW, YELLOW, ALL_RED};

  traffic_ctrl_param #(
    .CNT_W(CNT_W), .GREEN_NS(GREEN_NS), .GREEN_EW(GREEN_EW), .YELLOW(YELLOW),
    .ALL_RED(ALL_RED), .EXT_STEP(EXT_STEP), .EXT_MAX(EXT_MAX)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .ext_ns(ext_ns), .ext_ew(ext_ew),
    .flash(flash), .ns_green(ns_green), .ns_yellow(ns_yellow), .ns_red(ns_red),
    .ew_green(ew_green), .ew_yellow(ew_yellow), .ew_red(ew_red), .phase(phase),
    .timer(timer), .cycle_start(cycle_start)
  );

  assign lamps = {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red};

  always #5 clk = ~clk;

  function automatic logic [5:0] exp_lamps(input int p, input bit fy);
    case (p)
      0: return 6'b100_001;
      1: return 6'b010_001;
      3: return 6'b001_100;
      4: return 6'b001_010;
      6: return {1'b0, fy, 1'b0, 1'b0, fy, 1'b0};
      default: return 6'b001_001;
    endcase
  endfunction

  task automatic model_step(input bit tk, input bit en, input bit ew, input bit fl,
                            input bit rs);
    int prev;
    bit wants;
    prev = m_phase;
    if (rs) begin
      m_phase = 5; m_timer = ALL_RED; m_ext = 0; m_fy = 0;
    end else if (fl) begin
      m_fy = (m_phase == 6) ? (m_fy ^ tk) : 1'b1;
      m_phase = 6; m_timer = 0; m_ext = 0;
    end else if (m_phase == 6) begin
      m_phase = 5; m_timer = ALL_RED;
    end else if (tk) begin
      wants = (m_phase == 0 && en) || (m_phase == 3 && ew);
      if (wants && m_ext < EXT_MAX) begin
        m_timer = m_timer - 1 + EXT_STEP;
        m_ext++;
      end else if (m_timer > 1) begin
        m_timer--;
      end else begin
        m_phase = (m_phase + 1) % 6;
        m_timer = dur_tab[m_phase];
        m_ext = 0;
      end
    end
    m_cs = !rs && m_phase == 0 && prev != 0;
  endtask

  task automatic cyc(input bit tk, input bit en, input bit ew, input bit fl, input bit rs);
    tick = tk; ext_ns = en; ext_ew = ew; flash = fl; reset = rs;
    @(posedge clk);
    model_step(tk, en, ew, fl, rs);
    #1;
  endtask

  task automatic tick_until(input int p, input bit en, input bit ew, output int n);
    n = 0;
    while (int'(phase) != p && n < 200) begin
      cyc(1'b1, en, ew, 1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic dwell(input int p, input bit en, input bit ew, output int n);
    n = 0;
    while (int'(phase) == p && n < 200) begin
      cyc(1'b1, en, ew, 1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic test_reset;
    cyc(0, 0, 0, 0, 1);
    total++; if (phase !== 3'd5) $display("FAIL reset_phase: got %0d want 5", phase);
    else passed++;
    total++; if (timer !== CNT_W'(ALL_RED)) $display("FAIL reset_timer: got %0d want %0d", timer, ALL_RED);
    else passed++;
    total++; if (lamps !== 6'b001_001) $display("FAIL reset_lamps: got %b want 001001", lamps);
    else passed++;
    total++; if (cycle_start !== 1'b0) $display("FAIL reset_cs: got %b want 0", cycle_start);
    else passed++;
    repeat (3) cyc(0, 1, 1, 0, 0);
    total++; if (phase !== 3'd5 || timer !== CNT_W'(ALL_RED))
      $display("FAIL no_tick_hold: got phase %0d timer %0d want 5/%0d", phase, timer, ALL_RED);
    else passed++;
  endtask

  task automatic test_nominal;
    int run_ph[$];
    int run_len[$];
    int cs_ticks[$];
    int exp_ph[7] = '{5, 0, 1, 2, 3, 4, 5};
    int exp_len[7] = '{1, 10, 3, 1, 10, 3, 1};
    int cur;
    bit bad_inv;
    cyc(0, 0, 0, 0, 1);
    bad_inv = 0;
    for (int t = 1; t <= 29; t++) begin
      cur = int'(phase);
      if (run_ph.size() > 0 && run_ph[run_ph.size()-1] == cur) run_len[run_len.size()-1]++;
      else begin run_ph.push_back(cur); run_len.push_back(1); end
      cyc(1, 0, 0, 0, 0);
      if (cycle_start) cs_ticks.push_back(t);
      if ((ns_red + ns_yellow + ns_green) != 1 || (ew_red + ew_yellow + ew_green) != 1 ||
          (!ns_red && !ew_red)) bad_inv = 1;
    end
    total++; if (run_ph.size() != 7) $display("FAIL nominal_runs: got %0d want 7", run_ph.size());
    else passed++;
    for (int i = 0; i < 7 && i < run_ph.size(); i++) begin
      total++;
      if (run_ph[i] != exp_ph[i] || run_len[i] != exp_len[i])
        $display("FAIL nominal_dwell[%0d]: got phase %0d x%0d want phase %0d x%0d",
                 i, run_ph[i], run_len[i], exp_ph[i], exp_len[i]);
      else passed++;
    end
    total++; if (phase !== 3'd0) $display("FAIL nominal_end: got %0d want 0", phase);
    else passed++;
    total++;
    if (cs_ticks.size() != 2 || cs_ticks[0] != 1 || cs_ticks[1] != 29)
      $display("FAIL nominal_cycle_start: got %0d pulses want ticks 1 and 29", cs_ticks.size());
    else passed++;
    total++; if (bad_inv) $display("FAIL lamp_invariant: got violation want none");
    else passed++;
  endtask

  task automatic test_ext_ns;
    int n;
    cyc(0, 0, 0, 0, 1);
    tick_until(0, 0, 0, n);
    total++; if (phase !== 3'd0) $display("FAIL ext_ns_reach: got %0d want 0", phase);
    else passed++;
    dwell(0, 1, 0, n);
    total++; if (n != 20) $display("FAIL ext_ns_dwell: got %0d want 20", n);
    else passed++;
    tick_until(3, 0, 0, n);
    dwell(3, 0, 1, n);
    total++; if (n != 20) $display("FAIL ext_ew_after_clear: got %0d want 20", n);
    else passed++;
  endtask

  task automatic test_ext_boundary;
    int n;
    cyc(0, 0, 0, 0, 1);
    tick_until(3, 0, 0, n);
    repeat (9) cyc(1, 0, 0, 0, 0);
    total++; if (phase !== 3'd3 || timer !== 6'd1)
      $display("FAIL ext_edge_setup: got phase %0d timer %0d want 3/1", phase, timer);
    else passed++;
    cyc(1, 0, 1, 0, 0);
    total++; if (phase !== 3'd3 || timer !== 6'd5)
      $display("FAIL ext_edge_wins: got phase %0d timer %0d want 3/5", phase, timer);
    else passed++;
    repeat (4) cyc(1, 0, 0, 0, 0);
    total++; if (phase !== 3'd3 || timer !== 6'd1)
      $display("FAIL ext_edge_hold: got phase %0d timer %0d want 3/1", phase, timer);
    else passed++;
    cyc(1, 0, 0, 0, 0);
    total++; if (phase !== 3'd4 || timer !== CNT_W'(YELLOW))
      $display("FAIL ext_edge_yellow: got phase %0d timer %0d want 4/%0d", phase, timer, YELLOW);
    else passed++;
  endtask

  task automatic test_ext_ignored;
    int n;
    cyc(0, 0, 0, 0, 1);
    tick_until(2, 0, 0, n);
    cyc(1, 1, 0, 0, 0);
    dwell(3, 1, 0, n);
    total++; if (n != 10) $display("FAIL ext_wrong_phase: got %0d want 10", n);
    else passed++;
    tick_until(0, 0, 0, n);
    dwell(0, 0, 0, n);
    total++; if (n != 10) $display("FAIL ext_not_queued: got %0d want 10", n);
    else passed++;
  endtask

  task automatic test_flash;
    int n;
    logic exp_y;
    cyc(0, 0, 0, 0, 1);
    tick_until(3, 0, 0, n);
    repeat (4) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 1, 0);
      exp_y = (i % 2 == 0);
      total++;
      if (phase !== 3'd6 || timer !== 6'd0 || lamps !== {1'b0, exp_y, 1'b0, 1'b0, exp_y, 1'b0})
        $display("FAIL flash_step[%0d]: got phase %0d timer %0d lamps %b want 6/0 yellow %b",
                 i, phase, timer, lamps, exp_y);
      else passed++;
    end
    cyc(0, 0, 0, 0, 0);
    total++; if (phase !== 3'd5 || timer !== CNT_W'(ALL_RED) || lamps !== 6'b001_001)
      $display("FAIL flash_exit: got phase %0d timer %0d lamps %b want 5/1/001001",
               phase, timer, lamps);
    else passed++;
    cyc(1, 0, 0, 0, 0);
    total++; if (phase !== 3'd0 || cycle_start !== 1'b1)
      $display("FAIL flash_resume: got phase %0d cs %b want 0/1", phase, cycle_start);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int n;
    cyc(0, 0, 0, 0, 1);
    tick_until(1, 0, 0, n);
    cyc(1, 0, 0, 0, 0);
    total++; if (phase !== 3'd1 || timer !== 6'd2)
      $display("FAIL mid_setup: got phase %0d timer %0d want 1/2", phase, timer);
    else passed++;
    cyc(1, 0, 0, 0, 1);
    total++; if (phase !== 3'd5 || timer !== CNT_W'(ALL_RED) || lamps !== 6'b001_001)
      $display("FAIL mid_reset: got phase %0d timer %0d lamps %b want 5/1/001001",
               phase, timer, lamps);
    else passed++;
    repeat (2) cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 1);
    total++; if (phase !== 3'd5 || lamps !== 6'b001_001)
      $display("FAIL flash_reset: got phase %0d lamps %b want 5/001001", phase, lamps);
    else passed++;
  endtask

  task automatic test_random;
    int fl_hold;
    bit tk, en, ew, fl, rs;
    fl_hold = 0;
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      tk = ($urandom_range(0, 9) < 6);
      en = ($urandom_range(0, 2) == 0);
      ew = ($urandom_range(0, 2) == 0);
      if (fl_hold > 0) fl_hold--;
      else if ($urandom_range(0, 149) == 0) fl_hold = $urandom_range(1, 12);
      fl = (fl_hold > 0);
      rs = ($urandom_range(0, 399) == 0);
      cyc(tk, en, ew, fl, rs);
      total++; if (phase !== 3'(m_phase))
        $display("FAIL rand_phase@%0d: got %0d want %0d", i, phase, m_phase);
      else passed++;
      total++; if (timer !== CNT_W'(m_timer))
        $display("FAIL rand_timer@%0d: got %0d want %0d", i, timer, m_timer);
      else passed++;
      total++; if (lamps !== exp_lamps(m_phase, m_fy))
        $display("FAIL rand_lamps@%0d: got %b want %b", i, lamps, exp_lamps(m_phase, m_fy));
      else passed++;
      total++; if (cycle_start !== m_cs)
        $display("FAIL rand_cs@%0d: got %b want %b", i, cycle_start, m_cs);
      else passed++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_ext_ns();
    test_ext_boundary();
    test_ext_ignored();
    test_flash();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
